// File: rtl/alu_issue.sv
// alu_issue: registered MIPS ALU decode feeding a two-entry elastic (OUT + SKID) issue buffer
module alu_issue #(
  parameter int NB_DATA      = 32,
  parameter int NB_OPERATION = 4,
  parameter int NB_INSTR     = 32,
  parameter int NB_REG_ADDR  = 5
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic                    i_flush,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [NB_INSTR-1:0]     i_instr,
  input  logic [NB_DATA-1:0]      i_rs_data,
  input  logic [NB_DATA-1:0]      i_rt_data,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [NB_OPERATION-1:0] o_op,
  output logic [NB_DATA-1:0]      o_data_a,
  output logic [NB_DATA-1:0]      o_data_b,
  output logic [NB_REG_ADDR-1:0]  o_wr_reg,
  output logic                    o_illegal
);
  localparam logic [NB_OPERATION-1:0] OP_ADD = 'd0;
  localparam logic [NB_OPERATION-1:0] OP_SUB = 'd1;
  localparam logic [NB_OPERATION-1:0] OP_AND = 'd2;
  localparam logic [NB_OPERATION-1:0] OP_OR  = 'd3;
  localparam logic [NB_OPERATION-1:0] OP_XOR = 'd4;
  localparam logic [NB_OPERATION-1:0] OP_NOR = 'd5;
  localparam logic [NB_OPERATION-1:0] OP_SRL = 'd6;
  localparam logic [NB_OPERATION-1:0] OP_SLL = 'd7;
  localparam logic [NB_OPERATION-1:0] OP_SRA = 'd8;
  localparam logic [NB_OPERATION-1:0] OP_SLT = 'd10;
  localparam logic [NB_OPERATION-1:0] OP_LUI = 'd11;
  localparam logic [NB_OPERATION-1:0] OP_ILL = 'd15;

  typedef struct packed {
    logic [NB_OPERATION-1:0] op;
    logic [NB_DATA-1:0]      a;
    logic [NB_DATA-1:0]      b;
    logic [NB_REG_ADDR-1:0]  wr;
    logic                    ill;
  } ent_t;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  localparam ent_t BAD = '{OP_ILL, '0, '0, '0, 1'b1};

  function automatic ent_t mk(input logic [NB_OPERATION-1:0] op, input logic [NB_DATA-1:0] a,
                              input logic [NB_DATA-1:0] b, input logic [NB_REG_ADDR-1:0] wr);
    return '{op, a, b, wr, 1'b0};
  endfunction

  logic [5:0]             opc, funct;
  logic [NB_REG_ADDR-1:0] rt, rd;
  logic [15:0]            imm;
  logic [NB_DATA-1:0]     sext, zext, shz;
  logic [4:0]             unused_rs;
  ent_t                   dec, out_q, skid_q;
  state_t                 state, nxt;
  logic                   rdy_q, up, dn, ld_out, ld_skid;

  assign opc       = i_instr[31:26];
  assign funct     = i_instr[5:0];
  assign rt        = NB_REG_ADDR'(i_instr[20:16]);
  assign rd        = NB_REG_ADDR'(i_instr[15:11]);
  assign imm       = i_instr[15:0];
  assign unused_rs = i_instr[25:21];
  assign sext      = {{(NB_DATA-16){imm[15]}}, imm};
  assign zext      = {{(NB_DATA-16){1'b0}}, imm};
  assign shz       = {{(NB_DATA-5){1'b0}}, i_instr[10:6]};

  always_comb begin
    dec = BAD;
    case (opc)
      6'b000000:
        case (funct)
          6'b100000, 6'b100001: dec = mk(OP_ADD, i_rs_data, i_rt_data, rd);
          6'b100010, 6'b100011: dec = mk(OP_SUB, i_rs_data, i_rt_data, rd);
          6'b100100: dec = mk(OP_AND, i_rs_data, i_rt_data, rd);
          6'b100101: dec = mk(OP_OR,  i_rs_data, i_rt_data, rd);
          6'b100110: dec = mk(OP_XOR, i_rs_data, i_rt_data, rd);
          6'b100111: dec = mk(OP_NOR, i_rs_data, i_rt_data, rd);
          6'b101010: dec = mk(OP_SLT, i_rs_data, i_rt_data, rd);
          6'b000000: dec = mk(OP_SLL, i_rt_data, shz, rd);
          6'b000010: dec = mk(OP_SRL, i_rt_data, shz, rd);
          6'b000011: dec = mk(OP_SRA, i_rt_data, shz, rd);
          6'b000100: dec = mk(OP_SLL, i_rt_data, i_rs_data, rd);
          6'b000110: dec = mk(OP_SRL, i_rt_data, i_rs_data, rd);
          6'b000111: dec = mk(OP_SRA, i_rt_data, i_rs_data, rd);
          default:   dec = BAD;
        endcase
      6'b001000, 6'b001001, 6'b100011: dec = mk(OP_ADD, i_rs_data, sext, rt);
      6'b001010: dec = mk(OP_SLT, i_rs_data, sext, rt);
      6'b001100: dec = mk(OP_AND, i_rs_data, zext, rt);
      6'b001101: dec = mk(OP_OR,  i_rs_data, zext, rt);
      6'b001110: dec = mk(OP_XOR, i_rs_data, zext, rt);
      6'b001111: dec = mk(OP_LUI, '0, zext, rt);
      6'b101011: dec = mk(OP_ADD, i_rs_data, sext, '0);
      default:   dec = BAD;
    endcase
  end

  assign up = i_valid & rdy_q;
  assign dn = (state != EMPTY) & i_ready;

  always_comb begin
    nxt     = i_flush ? EMPTY :
              state == EMPTY ? (up ? ONE : EMPTY) :
              state == ONE   ? (up & !dn ? TWO : !up & dn ? EMPTY : ONE) :
              (dn ? ONE : TWO);
    ld_out  = !i_flush & (state == TWO ? dn : up & (state == EMPTY | dn));
    ld_skid = !i_flush & (state == ONE) & up & !dn;
  end

  // SKID only ever refills OUT from state TWO, where no new entry can arrive
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state  <= EMPTY;
      rdy_q  <= 1'b1;
      out_q  <= '0;
      skid_q <= '0;
    end else begin
      state <= nxt;
      rdy_q <= nxt != TWO;
      if (ld_out) out_q <= state == TWO ? skid_q : dec;
      if (ld_skid) skid_q <= dec;
    end
  end

  assign o_ready   = rdy_q;
  assign o_valid   = state != EMPTY;
  assign o_op      = out_q.op;
  assign o_data_a  = out_q.a;
  assign o_data_b  = out_q.b;
  assign o_wr_reg  = out_q.wr;
  assign o_illegal = out_q.ill;
endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: table-driven decode vectors plus handshake, flush and reset sequences
module tb_alu_issue;
  logic        clk = 1'b0, rst, flush, valid_in, ready_in;
  logic        o_ready, o_valid, o_illegal;
  logic [31:0] instr, rs_data, rt_data, o_data_a, o_data_b;
  logic [3:0]  o_op;
  logic [4:0]  o_wr_reg;
  int          errors = 0, checks = 0;

  alu_issue dut (
    .i_clock(clk), .i_reset(rst), .i_flush(flush), .i_valid(valid_in), .o_ready(o_ready),
    .i_instr(instr), .i_rs_data(rs_data), .i_rt_data(rt_data), .o_valid(o_valid),
    .i_ready(ready_in), .o_op(o_op), .o_data_a(o_data_a), .o_data_b(o_data_b),
    .o_wr_reg(o_wr_reg), .o_illegal(o_illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    string       name;
    logic [31:0] instr, rs, rt;
    logic [3:0]  op;
    logic [31:0] a, b;
    logic [4:0]  wr;
    logic        ill;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic chk_ent(input string n, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] wr, input logic ill);
    chk({n, " valid"}, 32'(o_valid), 32'd1);
    chk({n, " op"}, 32'(o_op), 32'(op));
    chk({n, " a"}, o_data_a, a);
    chk({n, " b"}, o_data_b, b);
    chk({n, " wr"}, 32'(o_wr_reg), 32'(wr));
    chk({n, " ill"}, 32'(o_illegal), 32'(ill));
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] rs);
    valid_in = v;
    instr    = ins;
    rs_data  = rs;
    rt_data  = 32'h0;
  endtask

  localparam logic [31:0] ADDI = 32'h20220000;

  task automatic fill_two;
    ready_in = 1'b0;
    drive(1, ADDI, 32'hA);
    step();
    drive(1, ADDI, 32'hB);
    step();
  endtask

  initial begin
    vecs[0]  = '{"addi",   32'h2067FFFF, 32'h5,        32'h0,        4'h0, 32'h5,        32'hFFFFFFFF, 5'd7, 1'b0};
    vecs[1]  = '{"sll",    32'h000227C0, 32'h0,        32'h1,        4'h7, 32'h1,        32'd31,       5'd4, 1'b0};
    vecs[2]  = '{"lui",    32'h3C051234, 32'hDEAD,     32'h0,        4'hB, 32'h0,        32'h00001234, 5'd5, 1'b0};
    vecs[3]  = '{"badop",  32'hFFFFFFFF, 32'h1234,     32'h5678,     4'hF, 32'h0,        32'h0,        5'd0, 1'b1};
    vecs[4]  = '{"sub",    32'h00221822, 32'd10,       32'd3,        4'h1, 32'd10,       32'd3,        5'd3, 1'b0};
    vecs[5]  = '{"srav",   32'h00C94007, 32'd4,        32'h80000000, 4'h8, 32'h80000000, 32'd4,        5'd8, 1'b0};
    vecs[6]  = '{"ori",    32'h34228001, 32'h11,       32'h0,        4'h3, 32'h11,       32'h00008001, 5'd2, 1'b0};
    vecs[7]  = '{"sw",     32'hAFA4FFFC, 32'h100,      32'h9,        4'h0, 32'h100,      32'hFFFFFFFC, 5'd0, 1'b0};
    vecs[8]  = '{"slti",   32'h28438000, 32'd7,        32'h0,        4'hA, 32'd7,        32'hFFFF8000, 5'd3, 1'b0};
    vecs[9]  = '{"badfn",  32'h00200008, 32'h1,        32'h2,        4'hF, 32'h0,        32'h0,        5'd0, 1'b1};
    vecs[10] = '{"nor",    32'h00222827, 32'h0F0F0F0F, 32'h00FF00FF, 4'h5, 32'h0F0F0F0F, 32'h00FF00FF, 5'd5, 1'b0};

    rst = 1'b1; flush = 1'b0; valid_in = 1'b0; ready_in = 1'b1;
    instr = '0; rs_data = '0; rt_data = '0;
    step();
    step();
    rst = 1'b0;
    chk("rst valid", 32'(o_valid), 0);
    chk("rst ready", 32'(o_ready), 1);
    chk("rst op", 32'(o_op), 0);
    chk("rst a", o_data_a, 0);
    chk("rst b", o_data_b, 0);

    // back-to-back vectors with i_ready held high: one entry out per cycle
    for (int i = 0; i < 11; i++) begin
      valid_in = 1'b1;
      instr    = vecs[i].instr;
      rs_data  = vecs[i].rs;
      rt_data  = vecs[i].rt;
      step();
      chk_ent(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].wr, vecs[i].ill);
      chk({vecs[i].name, " ready"}, 32'(o_ready), 1);
    end
    valid_in = 1'b0;
    step();
    chk("drain valid", 32'(o_valid), 0);

    // stall: A in OUT, B in SKID, C held upstream, then drain in order
    fill_two();
    chk("stall ready", 32'(o_ready), 0);
    chk_ent("stall out", 4'h0, 32'hA, 32'h0, 5'd2, 1'b0);
    drive(1, ADDI, 32'hC);
    step();
    chk("held ready", 32'(o_ready), 0);
    chk_ent("held out", 4'h0, 32'hA, 32'h0, 5'd2, 1'b0);
    ready_in = 1'b1;
    step();
    chk_ent("drain b", 4'h0, 32'hB, 32'h0, 5'd2, 1'b0);
    chk("drain b ready", 32'(o_ready), 1);
    step();
    chk_ent("drain c", 4'h0, 32'hC, 32'h0, 5'd2, 1'b0);
    valid_in = 1'b0;
    step();
    chk("drain end", 32'(o_valid), 0);

    // flush in TWO with a new entry offered: nothing ever emerges
    fill_two();
    drive(1, ADDI, 32'hC);
    flush = 1'b1;
    step();
    flush = 1'b0;
    valid_in = 1'b0;
    ready_in = 1'b1;
    chk("flush valid", 32'(o_valid), 0);
    chk("flush ready", 32'(o_ready), 1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("post flush valid", 32'(o_valid), 0);
    end

    // flush in ONE while an input and output transfer are both offered
    drive(1, ADDI, 32'hD);
    step();
    chk_ent("one d", 4'h0, 32'hD, 32'h0, 5'd2, 1'b0);
    drive(1, ADDI, 32'hE);
    flush = 1'b1;
    step();
    flush = 1'b0;
    valid_in = 1'b0;
    chk("flush one valid", 32'(o_valid), 0);
    step();
    chk("flush one stays", 32'(o_valid), 0);

    // reset in TWO beats flush and transfers
    fill_two();
    rst = 1'b1; flush = 1'b1; ready_in = 1'b1;
    step();
    rst = 1'b0; flush = 1'b0; valid_in = 1'b0;
    chk("rst2 valid", 32'(o_valid), 0);
    chk("rst2 ready", 32'(o_ready), 1);
    chk("rst2 op", 32'(o_op), 0);
    chk("rst2 a", o_data_a, 0);
    chk("rst2 b", o_data_b, 0);
    chk("rst2 wr", 32'(o_wr_reg), 0);
    chk("rst2 ill", 32'(o_illegal), 0);
    step();
    chk("rst2 stays", 32'(o_valid), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
